// File: rtl/mem_stage_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_if
// Bundles the EX/MEM-to-MEM access signals and the returned load data.
//   MemRead     : load request
//   MemWrite    : store request
//   RW_type     : access type (funct3)
//   addr        : byte address (ALU result)
//   Wr_mem_data : store data
//   loaddata    : combinational load result back to the MEM/WB register
// master = pipeline side driving the request, slave = memory stage.
// -----------------------------------------------------------------------------
interface mem_stage_lsu_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  RW_type;
  logic [31:0] addr;
  logic [31:0] Wr_mem_data;
  logic [31:0] loaddata;

  modport master (
    output MemRead, MemWrite, RW_type, addr, Wr_mem_data,
    input  loaddata
  );

  modport slave (
    input  MemRead, MemWrite, RW_type, addr, Wr_mem_data,
    output loaddata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM stage of the RV32I pipeline: word-organised data RAM with byte-lane
// writes, a 16-byte MMIO window (gpio, cycle counter, store counter) and a
// sticky misaligned-access error capture.
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : request/loaddata interface (slave modport)
//   gpio_o       : GPIO output register
//   misalign_err : sticky misaligned-access flag
//   err_addr     : address of the first misaligned access since last clear
//   err_clr      : synchronous clear of misalign_err / err_addr
// loaddata is combinational (zero-cycle load latency) so MEM/WB can capture it
// on the same edge as the ALU result.
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_stage_lsu_if.slave        bus,
  output logic [31:0]           gpio_o,
  output logic                  misalign_err,
  output logic [31:0]           err_addr,
  input  logic                  err_clr
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [31:0]   gpio_r;
  logic [31:0]   cycle_cnt_r;
  logic [31:0]   store_cnt_r;
  logic          misalign_err_r;
  logic [31:0]   err_addr_r;

  logic          access_s;
  logic          type_ok_s;
  logic          misalign_s;
  logic          err_set_s;
  logic          in_ram_s;
  logic          in_mmio_s;
  logic [1:0]    mmio_sel_s;
  logic [AW-1:0] word_idx_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic          ram_we_s;
  logic          gpio_we_s;
  logic [31:0]   rd_word_s;
  logic [7:0]    rd_byte_s;
  logic [15:0]   rd_half_s;
  logic [31:0]   load_s;

  assign access_s   = bus.MemRead | bus.MemWrite;
  assign in_ram_s   = (bus.addr < RAM_BYTES);
  assign in_mmio_s  = (bus.addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_sel_s = bus.addr[3:2];
  assign word_idx_s = bus.addr[AW+1:2];

  // Access-type legality and alignment; checked ahead of address decode.
  always_comb begin
    type_ok_s  = 1'b0;
    misalign_s = 1'b0;
    case (bus.RW_type)
      RW_B, RW_BU: begin
        type_ok_s  = 1'b1;
        misalign_s = 1'b0;
      end
      RW_H, RW_HU: begin
        type_ok_s  = 1'b1;
        misalign_s = bus.addr[0];
      end
      RW_W: begin
        type_ok_s  = 1'b1;
        misalign_s = (bus.addr[1:0] != 2'b00);
      end
      default: begin
        type_ok_s  = 1'b0;
        misalign_s = 1'b0;
      end
    endcase
  end

  assign err_set_s = access_s & misalign_s;

  // Byte enables and lane-replicated store data.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    case (bus.RW_type)
      RW_B, RW_BU: begin
        be_s    = 4'b0001 << bus.addr[1:0];
        wdata_s = {4{bus.Wr_mem_data[7:0]}};
      end
      RW_H, RW_HU: begin
        be_s    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{bus.Wr_mem_data[15:0]}};
      end
      RW_W: begin
        be_s    = 4'b1111;
        wdata_s = bus.Wr_mem_data;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  assign ram_we_s  = bus.MemWrite & type_ok_s & ~misalign_s & in_ram_s;
  // gpio accepts only aligned word stores; narrower stores are dropped.
  assign gpio_we_s = bus.MemWrite & (bus.RW_type == RW_W) & ~misalign_s &
                     in_mmio_s & (mmio_sel_s == 2'b00);

  // Source word selection for loads.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    if (in_ram_s) begin
      rd_word_s = mem_r[word_idx_s];
    end else if (in_mmio_s) begin
      case (mmio_sel_s)
        2'b00:   rd_word_s = gpio_r;
        2'b01:   rd_word_s = cycle_cnt_r;
        2'b10:   rd_word_s = store_cnt_r;
        default: rd_word_s = 32'h0000_0000;
      endcase
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  // Lane extraction and sign/zero extension.
  always_comb begin
    rd_byte_s = 8'h00;
    case (bus.addr[1:0])
      2'b00:   rd_byte_s = rd_word_s[7:0];
      2'b01:   rd_byte_s = rd_word_s[15:8];
      2'b10:   rd_byte_s = rd_word_s[23:16];
      2'b11:   rd_byte_s = rd_word_s[31:24];
      default: rd_byte_s = 8'h00;
    endcase
    rd_half_s = bus.addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    case (bus.RW_type)
      RW_B:    load_s = {{24{rd_byte_s[7]}}, rd_byte_s};
      RW_BU:   load_s = {24'h00_0000, rd_byte_s};
      RW_H:    load_s = {{16{rd_half_s[15]}}, rd_half_s};
      RW_HU:   load_s = {16'h0000, rd_half_s};
      RW_W:    load_s = rd_word_s;
      default: load_s = 32'h0000_0000;
    endcase
  end

  // A simultaneous read+write is a store only, so no load data is returned.
  always_comb begin
    if (bus.MemRead && !bus.MemWrite && !misalign_s) begin
      bus.loaddata = load_s;
    end else begin
      bus.loaddata = 32'h0000_0000;
    end
  end

  // Data RAM with byte-lane writes; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // MMIO registers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_r      <= 32'h0000_0000;
      cycle_cnt_r <= 32'h0000_0000;
      store_cnt_r <= 32'h0000_0000;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
      if (gpio_we_s) begin
        gpio_r <= bus.Wr_mem_data;
      end
      if (ram_we_s) begin
        store_cnt_r <= store_cnt_r + 32'd1;
      end
    end
  end

  // Sticky misalignment capture; a new error in the clear cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err_r <= 1'b0;
      err_addr_r     <= 32'h0000_0000;
    end else if (err_set_s) begin
      misalign_err_r <= 1'b1;
      if (!misalign_err_r || err_clr) begin
        err_addr_r <= bus.addr;
      end
    end else if (err_clr) begin
      misalign_err_r <= 1'b0;
      err_addr_r     <= 32'h0000_0000;
    end
  end

  assign gpio_o       = gpio_r;
  assign misalign_err = misalign_err_r;
  assign err_addr     = err_addr_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed bench for mem_stage_lsu with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled before
// the next rising edge.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

  localparam logic [31:0] MB   = 32'h0000_1000;
  localparam logic [2:0]  T_B  = 3'b000;
  localparam logic [2:0]  T_H  = 3'b001;
  localparam logic [2:0]  T_W  = 3'b010;
  localparam logic [2:0]  T_BU = 3'b100;
  localparam logic [2:0]  T_HU = 3'b101;
  localparam logic [2:0]  T_RS = 3'b011;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic [31:0] gpio_o;
  logic        misalign_err;
  logic [31:0] err_addr;

  int n_vec;
  int n_err;

  logic [31:0] v1;
  logic [31:0] v2;
  logic [31:0] v3;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(
    .DEPTH_WORDS (256),
    .MMIO_BASE   (32'h0000_1000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .gpio_o       (gpio_o),
    .misalign_err (misalign_err),
    .err_addr     (err_addr),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    bus.MemRead     = rd;
    bus.MemWrite    = wr;
    bus.RW_type     = t;
    bus.addr        = a;
    bus.Wr_mem_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, t, a, d);
    step();
    drive(1'b0, 1'b0, T_W, 32'h0, 32'h0);
  endtask

  task automatic load(input string tag, input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] exp);
    drive(1'b1, 1'b0, t, a, 32'h0);
    #1;
    check(tag, bus.loaddata, exp);
    step();
    drive(1'b0, 1'b0, T_W, 32'h0, 32'h0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    err_clr = 1'b0;
    drive(1'b0, 1'b0, T_W, 32'h0, 32'h0);
    #2;
    check("rst_gpio", gpio_o, 32'h0);
    check("rst_err", {31'h0, misalign_err}, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // 1: word store, then narrow loads with extension
    store(T_W, 32'h10, 32'h8081_F0F7);
    load("lw_10", T_W, 32'h10, 32'h8081_F0F7);
    load("lb_10", T_B, 32'h10, 32'hFFFF_FFF7);
    load("lbu_11", T_BU, 32'h11, 32'h0000_00F0);
    load("lh_12", T_H, 32'h12, 32'hFFFF_8081);
    load("lhu_12", T_HU, 32'h12, 32'h0000_8081);
    load("lb_13", T_B, 32'h13, 32'hFFFF_FF80);

    // 2: byte/half lane merge; store_cnt includes the store from step 1
    store(T_W, 32'h20, 32'hFFFF_FFFF);
    store(T_B, 32'h21, 32'h0000_0012);
    store(T_H, 32'h22, 32'h0000_ABCD);
    load("lw_20_merge", T_W, 32'h20, 32'hABCD_12FF);
    load("store_cnt_4", T_W, MB + 32'h8, 32'd4);

    // 3: misalignment capture and clear
    store(T_W, 32'h04, 32'h1111_1111);
    store(T_W, 32'h06, 32'h2222_2222);
    check("mis_flag", {31'h0, misalign_err}, 32'h1);
    check("mis_addr", err_addr, 32'h06);
    load("lw_04_unchanged", T_W, 32'h04, 32'h1111_1111);
    load("lh_0b_zero", T_H, 32'h0B, 32'h0);
    check("mis_addr_kept", err_addr, 32'h06);
    load("store_cnt_5", T_W, MB + 32'h8, 32'd5);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_flag", {31'h0, misalign_err}, 32'h0);
    check("clr_addr", err_addr, 32'h0);
    err_clr = 1'b1;
    load("lw_31_zero", T_W, 32'h31, 32'h0);
    err_clr = 1'b0;
    check("clr_new_flag", {31'h0, misalign_err}, 32'h1);
    check("clr_new_addr", err_addr, 32'h31);

    // 4: gpio and cycle counter
    store(T_W, MB, 32'hDEAD_BEEF);
    check("gpio_sw", gpio_o, 32'hDEAD_BEEF);
    store(T_B, MB, 32'h0000_0077);
    check("gpio_sb_ignored", gpio_o, 32'hDEAD_BEEF);
    load("gpio_lb_1", T_B, MB + 32'h1, 32'hFFFF_FFBE);
    load("gpio_lhu_2", T_HU, MB + 32'h2, 32'h0000_DEAD);
    load("store_cnt_mmio", T_W, MB + 32'h8, 32'd5);
    drive(1'b1, 1'b0, T_W, MB + 32'h4, 32'h0);
    #1;
    v1 = bus.loaddata;
    repeat (5) step();
    #1;
    v2 = bus.loaddata;
    check("cycle_delta_5", v2 - v1, 32'd5);
    step();
    drive(1'b0, 1'b1, T_W, MB + 32'h4, 32'h0);
    step();
    drive(1'b1, 1'b0, T_W, MB + 32'h4, 32'h0);
    #1;
    v3 = bus.loaddata;
    check("cycle_ro_delta_2", v3 - v2, 32'd2);
    step();
    drive(1'b0, 1'b0, T_W, 32'h0, 32'h0);

    // 5: unmapped, reserved type, read+write together
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_again", {31'h0, misalign_err}, 32'h0);
    store(T_W, 32'h00, 32'h0102_0304);
    load("lw_800_zero", T_W, 32'h800, 32'h0);
    store(T_W, 32'h800, 32'hAAAA_AAAA);
    load("lw_00_no_alias", T_W, 32'h00, 32'h0102_0304);
    store(T_RS, 32'h00, 32'hFFFF_FFFF);
    load("lw_00_reserved", T_W, 32'h00, 32'h0102_0304);
    check("reserved_no_err", {31'h0, misalign_err}, 32'h0);
    load("ld_reserved_zero", T_RS, 32'h00, 32'h0);
    drive(1'b0, 1'b0, T_W, 32'h00, 32'h0);
    #1;
    check("noread_zero", bus.loaddata, 32'h0);
    drive(1'b1, 1'b1, T_W, 32'h40, 32'h0000_1234);
    #1;
    check("rdwr_zero", bus.loaddata, 32'h0);
    step();
    drive(1'b0, 1'b0, T_W, 32'h0, 32'h0);
    load("lw_40", T_W, 32'h40, 32'h0000_1234);
    load("store_cnt_7", T_W, MB + 32'h8, 32'd7);

    // 6: asynchronous reset mid-cycle
    store(T_W, MB, 32'hCAFE_F00D);
    store(T_W, 32'h02, 32'h0);
    check("pre_rst_gpio", gpio_o, 32'hCAFE_F00D);
    check("pre_rst_err", {31'h0, misalign_err}, 32'h1);
    repeat (3) step();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_gpio", gpio_o, 32'h0);
    check("arst_err", {31'h0, misalign_err}, 32'h0);
    check("arst_err_addr", err_addr, 32'h0);
    drive(1'b1, 1'b0, T_W, MB + 32'h4, 32'h0);
    #1;
    check("arst_cycle", bus.loaddata, 32'h0);
    drive(1'b1, 1'b0, T_W, MB + 32'h8, 32'h0);
    #1;
    check("arst_store_cnt", bus.loaddata, 32'h0);
    drive(1'b0, 1'b0, T_W, 32'h0, 32'h0);
    step();
    rst_n = 1'b1;
    load("ram_keep_40", T_W, 32'h40, 32'h0000_1234);
    load("ram_keep_10", T_W, 32'h10, 32'h8081_F0F7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
